// File: rtl/audio_dac_sequencer.sv
// Stereo sample sequencer in front of sigma_delta_codec: sample FIFO, output-rate
// tick, soft-mute gain ramp FSM and registered gain scaling of the held sample.
module audio_dac_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAIN_MAX   = 16,
  parameter int GAIN_SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [15:0]                   s_left,
  input  logic [15:0]                   s_right,
  input  logic [11:0]                   rate_div,
  input  logic                          mute_req,
  output logic [15:0]                   audio_l,
  output logic [15:0]                   audio_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [7:0]                    underrun_cnt,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = GAIN_SHIFT + 1;
  localparam int PW = 16 + GW;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_PLAY      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   gain_reg, gain_next;
  logic [11:0]     cnt_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg, level_next;
  logic            underrun_reg;
  logic [7:0]      underrun_cnt_reg;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [31:0]     rd_word;

  logic tick;
  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic starve;

  assign tick       = (cnt_reg == 12'd0);
  assign active     = (state_reg != ST_IDLE);
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
  assign push       = s_valid && !fifo_full;
  // Pop/underrun decisions use the pre-edge FIFO state, so a same-cycle push never bypasses.
  assign pop        = tick && active && !fifo_empty;
  assign starve     = tick && active && fifo_empty;

  assign s_ready      = !fifo_full;
  assign fifo_level   = level_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;
  assign state        = state_reg;

  // Sample-rate divider: rate_div is sampled only on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= rate_div;
    end else begin
      cnt_reg <= cnt_reg - 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_left, s_right};
    end
  end

  assign rd_word = mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      underrun_reg <= starve;
      if (starve && (underrun_cnt_reg != 8'hFF)) begin
        underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gain_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gain_reg  <= gain_next;
    end
  end

  // Mute has priority over a same-cycle ramp step so the down-ramp starts from the current gain.
  always_comb begin
    state_next = state_reg;
    gain_next  = gain_reg;
    case (state_reg)
      ST_IDLE: begin
        gain_next = '0;
        if (!mute_req && (level_reg >= LW'(FIFO_DEPTH / 2))) begin
          state_next = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (mute_req) begin
          state_next = ST_RAMP_DOWN;
        end else if (tick) begin
          gain_next = gain_reg + GW'(1);
          if (gain_reg == GW'(GAIN_MAX - 1)) begin
            state_next = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (mute_req) begin
          state_next = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (gain_reg == '0) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          gain_next = gain_reg - GW'(1);
          if (gain_reg == GW'(1)) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        gain_next  = '0;
      end
    endcase
  end

  // Channel 1 is the left (upper) half of a FIFO word, channel 0 the right.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [15:0]   hold_reg;
      logic signed [PW-1:0] hold_ext;
      logic signed [PW-1:0] gain_ext;
      logic signed [PW-1:0] product;
      logic [15:0]          audio_reg;

      assign hold_ext = {{(PW - 16){hold_reg[15]}}, hold_reg};
      assign gain_ext = {{(PW - GW){1'b0}}, gain_reg};
      assign product  = hold_ext * gain_ext;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_reg  <= '0;
          audio_reg <= '0;
        end else begin
          if (pop) begin
            hold_reg <= rd_word[16*gi +: 16];
          end
          audio_reg <= 16'(product >>> GAIN_SHIFT);
        end
      end
    end
  endgenerate

  assign audio_l = g_chan[1].audio_reg;
  assign audio_r = g_chan[0].audio_reg;

endmodule

// File: tb/tb_audio_dac_sequencer.sv
// Bench for audio_dac_sequencer: directed scenarios plus random traffic, every
// cycle compared against a queue-based behavioural model of the sequencer.
module tb_audio_dac_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic [11:0] rate_div;
  logic        mute_req;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  audio_dac_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_left       (s_left),
    .s_right      (s_right),
    .rate_div     (rate_div),
    .mute_req     (mute_req),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .state        (state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: FIFO as a queue, gain and divider as plain integers.
  localparam int M_IDLE = 0, M_UP = 1, M_PLAY = 2, M_DOWN = 3;
  logic [31:0] mq[$];
  int          m_state, m_gain, m_cnt, m_ucnt;
  logic [15:0] m_hold_l, m_hold_r, m_audio_l, m_audio_r;
  bit          m_under, m_tick;

  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> 4;
    return p[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = M_IDLE; m_gain = 0; m_cnt = 0; m_ucnt = 0;
    m_hold_l = 0; m_hold_r = 0; m_audio_l = 0; m_audio_r = 0;
    m_under = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    int lvl;
    bit tk, act;
    logic [31:0] e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk  = (m_cnt == 0);
    lvl = mq.size();
    act = (m_state != M_IDLE);
    m_audio_l = scale(m_hold_l, m_gain);
    m_audio_r = scale(m_hold_r, m_gain);
    m_under = tk && act && (lvl == 0);
    if (m_under && m_ucnt < 255) m_ucnt++;
    if (tk && act && lvl != 0) begin
      e = mq.pop_front();
      m_hold_l = e[31:16];
      m_hold_r = e[15:0];
    end
    if (s_valid && lvl < DEPTH) mq.push_back({s_left, s_right});
    case (m_state)
      M_IDLE: if (!mute_req && lvl >= DEPTH / 2) m_state = M_UP;
      M_UP: begin
        if (mute_req) m_state = M_DOWN;
        else if (tk) begin
          m_gain++;
          if (m_gain == 16) m_state = M_PLAY;
        end
      end
      M_PLAY: if (mute_req) m_state = M_DOWN;
      default: begin
        if (m_gain == 0) m_state = M_IDLE;
        else if (tk) begin
          m_gain--;
          if (m_gain == 0) m_state = M_IDLE;
        end
      end
    endcase
    m_cnt  = tk ? int'(rate_div) : m_cnt - 1;
    m_tick = tk;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
    chk("audio_l", 32'(audio_l), 32'(m_audio_l));
    chk("audio_r", 32'(audio_r), 32'(m_audio_r));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_state(input int target, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (32'(state) == target) break;
      if (s_valid) begin s_left = 16'($urandom); s_right = 16'($urandom); end
      step();
    end
    chk(tag, 32'(state), 32'(target));
  endtask

  task automatic count_ramp(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (m_tick) n++;
      if (state == 2'd0) break;
    end
  endtask

  int          n_ticks, pulses, exp_pulses, lvl_snap, pv;
  logic [15:0] last_l;
  logic [15:0] seq[$];

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    rate_div = 12'd3; mute_req = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;

    // Prefill then ramp-up at rate_div=3
    s_valid = 1'b1; s_left = 16'h4000; s_right = 16'h4000;
    last_l = '0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (audio_l != last_l) begin seq.push_back(audio_l); last_l = audio_l; end
      if (audio_l == 16'h4000) break;
    end
    chk("ramp_steps", 32'(seq.size()), 32'd16);
    for (int k = 0; k < seq.size() && k < 16; k++)
      chk("ramp_val", 32'(seq[k]), 32'(16'h0400 * (k + 1)));
    chk("ramp_play", 32'(state), 32'd2);

    // Starve the FIFO until the underrun counter saturates
    s_valid = 1'b0; rate_div = 12'd0; pulses = 0; exp_pulses = 0;
    for (int i = 0; i < 420; i++) begin
      step();
      if (underrun) pulses++;
      if (m_under) exp_pulses++;
    end
    chk("ucnt_sat", 32'(underrun_cnt), 32'd255);
    chk("under_pulses", 32'(pulses), 32'(exp_pulses));
    chk("hold_last", 32'(audio_l), 32'h4000);

    // Soft mute from full-scale negative sample
    s_valid = 1'b1; s_left = 16'h8000; rate_div = 12'd1;
    for (int i = 0; i < 30; i++) begin s_right = 16'($urandom); step(); end
    chk("neg_full", 32'(audio_l), 32'h8000);
    mute_req = 1'b1;
    step();
    chk("mute_state", 32'(state), 32'd3);
    count_ramp(300, n_ticks);
    chk("mute_ticks", 32'(n_ticks), 32'd16);
    step();
    chk("mute_zero", 32'(audio_l), 32'h0);
    s_valid = 1'b0; lvl_snap = mq.size();
    repeat (20) step();
    chk("no_pop", 32'(fifo_level), 32'(lvl_snap));
    chk("idle_stay", 32'(state), 32'd0);

    // Abort ramp-up at gain 5
    mute_req = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (m_gain == 5 && m_state == M_UP) break;
      s_left = 16'($urandom); s_right = 16'($urandom);
      step();
    end
    mute_req = 1'b1;
    step();
    chk("abort_state", 32'(state), 32'd3);
    count_ramp(200, n_ticks);
    chk("abort_ticks", 32'(n_ticks), 32'd5);

    // Random traffic
    pv = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin rate_div = 12'($urandom_range(0, 3)); pv = $urandom_range(0, 100); end
      s_valid = ($urandom_range(0, 99) < pv);
      s_left = 16'($urandom); s_right = 16'($urandom);
      if ($urandom_range(0, 79) == 0) mute_req = ~mute_req;
      step();
    end

    // Asynchronous reset in the middle of PLAY
    mute_req = 1'b0; s_valid = 1'b1; rate_div = 12'd0;
    wait_state(2, 400, "reach_play");
    repeat (4) begin s_left = 16'h1234; s_right = 16'hCDEF; step(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_audio_l", 32'(audio_l), 32'h0);
    chk("arst_audio_r", 32'(audio_r), 32'h0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_ucnt", 32'(underrun_cnt), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1; s_valid = 1'b0;
    step();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
